// File: rtl/gemips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gemips_ctrl_pkg
// Description : Shared pipeline-control encodings: stall vectors and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package gemips_ctrl_pkg;

    localparam int STALL_W = 6;
    localparam int PC_W    = 32;
    localparam int CNT_W   = 16;

    // Hold vector bits: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        FLUSH    = 2'd2
    } ctrl_state_t;

    function automatic logic [STALL_W-1:0] stall_decode(
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [STALL_W-1:0] vec;
        vec = STALL_NONE;
        if (req_mem)      vec = STALL_MEM;
        else if (req_ex)  vec = STALL_EX;
        else if (req_id)  vec = STALL_ID;
        return vec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stall_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : stall_perf_cnt
// Description : Saturating performance counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module stall_perf_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] r_value;

    // Clear takes precedence over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc && (r_value != {WIDTH{1'b1}})) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard/stall control with deferred redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import gemips_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               flush_req,
    input  logic [PC_W-1:0]    flush_pc,
    input  logic               cnt_clr,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [PC_W-1:0]    new_pc,
    output logic [CNT_W-1:0]   stall_cnt
);

    ctrl_state_t        r_state;
    ctrl_state_t        w_next_state;
    logic               w_capture;
    logic [PC_W-1:0]    r_target;
    logic [PC_W-1:0]    w_redirect_pc;
    logic               r_flush;
    logic [PC_W-1:0]    r_new_pc;
    logic [STALL_W-1:0] w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A redirect is only accepted outside WAIT_MEM so the oldest target wins
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_stall      = STALL_NONE;
        case (r_state)
            RUN, FLUSH: begin
                if (flush_req) begin
                    w_capture    = 1'b1;
                    w_next_state = stallreq_mem ? WAIT_MEM : FLUSH;
                end else begin
                    w_next_state = RUN;
                end
            end
            WAIT_MEM: begin
                if (!stallreq_mem) begin
                    w_next_state = FLUSH;
                end
            end
            default: w_next_state = RUN;
        endcase
        if (!rst && (r_state != FLUSH)) begin
            w_stall = stall_decode(stallreq_id, stallreq_ex, stallreq_mem);
        end
    end

    assign w_redirect_pc = w_capture ? flush_pc : r_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= '0;
            r_flush  <= 1'b0;
            r_new_pc <= '0;
        end else begin
            if (w_capture) begin
                r_target <= flush_pc;
            end
            r_flush <= (w_next_state == FLUSH);
            if (w_next_state == FLUSH) begin
                r_new_pc <= w_redirect_pc;
            end
        end
    end

    stall_perf_cnt #(
        .WIDTH (CNT_W)
    ) u_stall_perf_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall[0]),
        .clr   (cnt_clr),
        .value (stall_cnt)
    );

    assign stall  = w_stall;
    assign flush  = r_flush;
    assign new_pc = r_new_pc;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        cnt_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [15:0] stall_cnt;

    int n_assert;
    int n_fail;

    pipe_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .cnt_clr      (cnt_clr),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b1;
        flush_req    = 1'b0;
        flush_pc     = 32'h0;
        cnt_clr      = 1'b0;

        // Reset: stall suppressed even with a memory request pending
        tick();
        tick();
        chk("rst_stall", 32'(stall), 32'h0);
        stallreq_mem = 1'b0;
        tick();
        rst = 1'b0;
        settle();
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_new_pc", new_pc, 32'h0);
        chk("rst_cnt", 32'(stall_cnt), 32'h0);

        // id+ex together -> ex encoding, counter +1 next cycle
        stallreq_id = 1'b1;
        stallreq_ex = 1'b1;
        settle();
        chk("stall_id_ex", 32'(stall), 32'h0F);
        tick();
        stallreq_id = 1'b0;
        stallreq_ex = 1'b0;
        settle();
        chk("cnt_after_1", 32'(stall_cnt), 32'h1);
        chk("stall_none", 32'(stall), 32'h0);

        // Priority decode
        stallreq_mem = 1'b1;
        stallreq_id  = 1'b1;
        settle();
        chk("stall_mem_prio", 32'(stall), 32'h1F);
        tick();
        stallreq_mem = 1'b0;
        settle();
        chk("stall_id_only", 32'(stall), 32'h07);
        tick();
        stallreq_id = 1'b0;
        settle();
        chk("cnt_after_3", 32'(stall_cnt), 32'h3);

        // Simple flush, no stalls
        flush_req = 1'b1;
        flush_pc  = 32'h0000_0380;
        tick();
        flush_req   = 1'b0;
        flush_pc    = 32'h0;
        stallreq_id = 1'b1;
        settle();
        chk("flush_hi", 32'(flush), 32'h1);
        chk("flush_pc", new_pc, 32'h0000_0380);
        chk("flush_stall0", 32'(stall), 32'h0);
        tick();
        stallreq_id = 1'b0;
        settle();
        chk("flush_lo", 32'(flush), 32'h0);
        chk("new_pc_hold", new_pc, 32'h0000_0380);
        chk("cnt_no_inc_flush", 32'(stall_cnt), 32'h3);

        // Flush deferred behind memory stall; second request ignored
        stallreq_mem = 1'b1;
        flush_req    = 1'b1;
        flush_pc     = 32'hBFC0_0380;
        tick();
        flush_pc = 32'h0000_0100;
        settle();
        chk("wm_flush_lo1", 32'(flush), 32'h0);
        tick();
        flush_req = 1'b0;
        settle();
        chk("wm_flush_lo2", 32'(flush), 32'h0);
        tick();
        stallreq_mem = 1'b0;
        settle();
        chk("wm_flush_lo3", 32'(flush), 32'h0);
        chk("wm_stall_none", 32'(stall), 32'h0);
        tick();
        chk("wm_flush_hi", 32'(flush), 32'h1);
        chk("wm_new_pc", new_pc, 32'hBFC0_0380);
        tick();
        chk("wm_flush_end", 32'(flush), 32'h0);
        chk("wm_pc_kept", new_pc, 32'hBFC0_0380);
        chk("cnt_after_wm", 32'(stall_cnt), 32'h6);

        // Back-to-back flushes
        flush_req = 1'b1;
        flush_pc  = 32'h0000_0100;
        tick();
        flush_pc = 32'h0000_0200;
        settle();
        chk("b2b_flush1", 32'(flush), 32'h1);
        chk("b2b_pc1", new_pc, 32'h0000_0100);
        tick();
        flush_req = 1'b0;
        settle();
        chk("b2b_flush2", 32'(flush), 32'h1);
        chk("b2b_pc2", new_pc, 32'h0000_0200);
        tick();
        chk("b2b_end", 32'(flush), 32'h0);

        // Reset while waiting on memory drops the redirect
        stallreq_mem = 1'b1;
        flush_req    = 1'b1;
        flush_pc     = 32'hDEAD_0000;
        tick();
        flush_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        stallreq_mem = 1'b0;
        settle();
        chk("rstwm_cnt", 32'(stall_cnt), 32'h0);
        chk("rstwm_new_pc", new_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstwm_no_flush", 32'(flush), 32'h0);
        end
        chk("rstwm_pc_after", new_pc, 32'h0);

        // Saturation and clear-over-increment
        stallreq_mem = 1'b1;
        repeat (65534) tick();
        chk("sat_fffe", 32'(stall_cnt), 32'h0000_FFFE);
        tick();
        chk("sat_ffff", 32'(stall_cnt), 32'h0000_FFFF);
        repeat (5) tick();
        chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        settle();
        chk("clr_wins", 32'(stall_cnt), 32'h0);
        tick();
        chk("cnt_resume", 32'(stall_cnt), 32'h1);
        stallreq_mem = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
